// File: rtl/bpmc_pulse_decoder_pkg.sv
// Shared definitions for the bipolar pulse-marker decoder and its generator
// counterpart: state encoding and the common counter defaults.
package bpmc_pulse_decoder_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

endpackage

// File: rtl/bpmc_pulse_decoder_if.sv
// Marker input / decoded-event output bundle for bpmc_pulse_decoder.
// The master side drives the pulse train and Clear; the slave side is the decoder.
interface bpmc_pulse_decoder_if
  import bpmc_pulse_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             Pin;
  logic             Clear;
  logic             Front_out;
  logic             Rear_out;
  logic             Level_out;
  logic [CNT_W-1:0] Width;
  logic             Width_vld;
  logic             Err_out;

  modport master (
    output Pin,
    output Clear,
    input  Front_out,
    input  Rear_out,
    input  Level_out,
    input  Width,
    input  Width_vld,
    input  Err_out
  );

  modport slave (
    input  Pin,
    input  Clear,
    output Front_out,
    output Rear_out,
    output Level_out,
    output Width,
    output Width_vld,
    output Err_out
  );

endinterface

// File: rtl/bpmc_pulse_decoder_pin_sync_edge.sv
// Synchroniser chain plus registered rising-edge detector for an asynchronous
// input. A level held high yields exactly one Rise pulse.
module pin_sync_edge #(
  parameter int unsigned SYNC = 2
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Din,
  output logic Rise
);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;

  // Shift Din through the synchroniser, keep one cycle of history, flag rising edges.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      Rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], Din};
      prev_q <= sync_q[SYNC-1];
      Rise   <= sync_q[SYNC-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/bpmc_pulse_decoder.sv
// Decodes a merged single-line marker pulse train into front/rear strobes,
// a rebuilt level, the front-to-rear width in cycles, and a timeout error.
module bpmc_pulse_decoder
  import bpmc_pulse_decoder_pkg::*;
#(
  parameter int unsigned      SYNC    = 2,
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
  input logic                  Clock,
  input logic                  Reset_n,
  bpmc_pulse_decoder_if.slave  bus
);

  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  pin_sync_edge #(
    .SYNC (SYNC)
  ) u_pin_sync_edge (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Din     (bus.Pin),
    .Rise    (rise)
  );

  // Front/rear state machine with interval counter; all outputs registered.
  // Clear is checked before the edge so a coincident edge is discarded.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.Width     <= '0;
      bus.Front_out <= 1'b0;
      bus.Rear_out  <= 1'b0;
      bus.Width_vld <= 1'b0;
      bus.Err_out   <= 1'b0;
      bus.Level_out <= 1'b0;
    end else begin
      bus.Front_out <= 1'b0;
      bus.Rear_out  <= 1'b0;
      bus.Width_vld <= 1'b0;
      bus.Err_out   <= 1'b0;
      if (bus.Clear) begin
        state         <= ST_IDLE;
        cnt           <= '0;
        bus.Level_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              bus.Front_out <= 1'b1;
              bus.Level_out <= 1'b1;
              cnt           <= CNT_W'(1);
              state         <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (rise) begin
              bus.Rear_out  <= 1'b1;
              bus.Width_vld <= 1'b1;
              bus.Width     <= cnt;
              bus.Level_out <= 1'b0;
              cnt           <= '0;
              state         <= ST_IDLE;
            end else if (cnt == TIMEOUT) begin
              bus.Err_out   <= 1'b1;
              bus.Level_out <= 1'b0;
              cnt           <= '0;
              state         <= ST_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bpmc_pulse_decoder.sv
// Scoreboard bench for bpmc_pulse_decoder: two instances (default TIMEOUT and
// TIMEOUT=8) share one expected-event queue; a negedge monitor checks strobes.
module tb_bpmc_pulse_decoder;

  localparam int K_FRONT = 0;
  localparam int K_REAR  = 1;
  localparam int K_ERR   = 2;
  localparam int K_BAD   = 9;

  typedef struct {
    int          dut;
    int          kind;
    logic [15:0] width;
    longint      cyc;
  } evt_t;

  logic   clk = 1'b0;
  logic   rst_n;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  evt_t   exp_q[$];

  bpmc_pulse_decoder_if #(.CNT_W(16)) bus_a ();
  bpmc_pulse_decoder_if #(.CNT_W(16)) bus_b ();

  bpmc_pulse_decoder #(
    .SYNC  (2),
    .CNT_W (16)
  ) dut_a (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus_a)
  );

  bpmc_pulse_decoder #(
    .SYNC    (2),
    .CNT_W   (16),
    .TIMEOUT (16'd8)
  ) dut_b (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input longint c);
    while (cyc < c) step();
  endtask

  task automatic push(input int d, input int k, input logic [15:0] w, input longint c);
    evt_t e;
    e.dut = d; e.kind = k; e.width = w; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic logic in_mk(input int i, input int s, input int len);
    return (s >= 0) && (i >= s) && (i < s + len);
  endfunction

  task automatic set_pin(input int d, input logic v);
    if (d == 0) bus_a.Pin = v; else bus_b.Pin = v;
  endtask

  task automatic set_clr(input int d, input logic v);
    if (d == 0) bus_a.Clear = v; else bus_b.Clear = v;
  endtask

  task automatic drive(input int d, input int s0, input int s1, input int s2, input int s3,
                       input int len, input int clr_at, input int total);
    for (int i = 0; i < total; i++) begin
      set_pin(d, in_mk(i, s0, len) | in_mk(i, s1, len) | in_mk(i, s2, len) | in_mk(i, s3, len));
      set_clr(d, i == clr_at);
      step();
    end
    set_pin(d, 1'b0);
    set_clr(d, 1'b0);
  endtask

  // Monitor: flag overdue expectations, then match every strobe against the queue head.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_event dut=%0d kind=%0d: got nothing, expected at cyc=%0d (now %0d)",
               exp_q[0].dut, exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int d = 0; d < 2; d++) begin
      logic        f, r, v, e;
      logic [15:0] w;
      int          k;
      evt_t        x;
      f = (d == 0) ? bus_a.Front_out : bus_b.Front_out;
      r = (d == 0) ? bus_a.Rear_out  : bus_b.Rear_out;
      v = (d == 0) ? bus_a.Width_vld : bus_b.Width_vld;
      e = (d == 0) ? bus_a.Err_out   : bus_b.Err_out;
      w = (d == 0) ? bus_a.Width     : bus_b.Width;
      if (f | r | v | e) begin
        checks++;
        if (f && !r && !v && !e)      k = K_FRONT;
        else if (r && v && !f && !e)  k = K_REAR;
        else if (e && !f && !r && !v) k = K_ERR;
        else                          k = K_BAD;
        if (exp_q.size() == 0 || exp_q[0].dut != d || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_strobe dut=%0d cyc=%0d: got kind=%0d f%b r%b v%b e%b, expected none",
                   d, cyc, k, f, r, v, e);
        end else begin
          x = exp_q.pop_front();
          if (k != x.kind || (k == K_REAR && w != x.width)) begin
            failures++;
            $display("FAIL event dut=%0d cyc=%0d: got kind=%0d width=%0d, expected kind=%0d width=%0d",
                     d, cyc, k, w, x.kind, x.width);
          end
        end
      end
    end
  end

  initial begin
    longint b;
    rst_n = 1'b0;
    bus_a.Pin = 1'b0; bus_a.Clear = 1'b0;
    bus_b.Pin = 1'b0; bus_b.Clear = 1'b0;

    // Reset with Pin toggling, release with Pin low, then 20 quiet cycles.
    for (int i = 0; i < 10; i++) begin
      bus_a.Pin = ~bus_a.Pin;
      bus_b.Pin = ~bus_b.Pin;
      step();
    end
    bus_a.Pin = 1'b0; bus_b.Pin = 1'b0;
    step();
    check("rst_level_a", bus_a.Level_out, 0);
    check("rst_front_a", bus_a.Front_out, 0);
    check("rst_width_a", bus_a.Width, 0);
    check("rst_level_b", bus_b.Level_out, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("idle_width_a", bus_a.Width, 0);
    check("idle_vld_a", bus_a.Width_vld, 0);
    check("idle_err_b", bus_b.Err_out, 0);
    check("idle_level_b", bus_b.Level_out, 0);

    // Basic decode: markers at 0 and 10 -> front +4, rear +14, width 10.
    b = cyc;
    push(0, K_FRONT, 0, b + 4);
    push(0, K_REAR, 16'd10, b + 14);
    fork
      drive(0, 0, 10, -1, -1, 3, -1, 24);
      begin
        wait_to(b + 3);  check("basic_level_pre", bus_a.Level_out, 0);
        wait_to(b + 4);  check("basic_level_on", bus_a.Level_out, 1);
        wait_to(b + 13); check("basic_level_end", bus_a.Level_out, 1);
        wait_to(b + 14); check("basic_level_off", bus_a.Level_out, 0);
      end
    join
    check("basic_width", bus_a.Width, 10);

    // Back-to-back markers 6 cycles apart.
    b = cyc;
    push(0, K_FRONT, 0, b + 4);
    push(0, K_REAR, 16'd6, b + 10);
    push(0, K_FRONT, 0, b + 16);
    push(0, K_REAR, 16'd6, b + 22);
    drive(0, 0, 6, 12, 18, 3, -1, 30);
    check("b2b_width", bus_a.Width, 6);

    // Boundary on TIMEOUT=8 instance: rear lands at cnt==TIMEOUT, rear wins.
    b = cyc;
    push(1, K_FRONT, 0, b + 4);
    push(1, K_REAR, 16'd8, b + 12);
    drive(1, 0, 8, -1, -1, 3, -1, 20);
    check("bound_width", bus_b.Width, 8);
    check("bound_level", bus_b.Level_out, 0);

    // Timeout: single marker, error 8 cycles after the front strobe.
    b = cyc;
    push(1, K_FRONT, 0, b + 4);
    push(1, K_ERR, 0, b + 12);
    fork
      drive(1, 0, -1, -1, -1, 3, -1, 20);
      begin
        wait_to(b + 11); check("to_level_hi", bus_b.Level_out, 1);
        wait_to(b + 12); check("to_level_lo", bus_b.Level_out, 0);
      end
    join
    check("to_width_hold", bus_b.Width, 8);

    // Clear at cnt=5, then a later marker decodes as a front (and times out).
    b = cyc;
    push(1, K_FRONT, 0, b + 4);
    push(1, K_FRONT, 0, b + 18);
    push(1, K_ERR, 0, b + 26);
    fork
      drive(1, 0, 14, -1, -1, 3, 8, 32);
      begin
        wait_to(b + 8); check("clr_level_before", bus_b.Level_out, 1);
        wait_to(b + 9); check("clr_level_after", bus_b.Level_out, 0);
      end
    join
    check("clr_width_hold", bus_b.Width, 8);

    // Stuck-high Pin: one front, then timeout, nothing further.
    b = cyc;
    push(1, K_FRONT, 0, b + 4);
    push(1, K_ERR, 0, b + 12);
    fork
      drive(1, 0, -1, -1, -1, 50, -1, 60);
      begin
        wait_to(b + 13); check("stuck_level", bus_b.Level_out, 0);
        wait_to(b + 40); check("stuck_level_late", bus_b.Level_out, 0);
      end
    join
    check("stuck_width_hold", bus_b.Width, 8);

    repeat (6) step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
